// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg
// Shared constants, command/state encodings and the fit-view sample tables
// for the LCD controller core.
package lcd_ctrl_pkg;

  localparam int IMG_W = 12;
  localparam int IMG_H = 9;
  localparam int WIN   = 4;

  localparam logic [3:0] DEF_R0 = 4'd2;
  localparam logic [3:0] DEF_C0 = 4'd4;
  localparam logic [3:0] MAX_R0 = 4'd5;
  localparam logic [3:0] MAX_C0 = 4'd8;

  typedef enum logic [2:0] {
    CMD_LOAD     = 3'd0,
    CMD_ZOOM_IN  = 3'd1,
    CMD_ZOOM_FIT = 3'd2,
    CMD_RIGHT    = 3'd3,
    CMD_LEFT     = 3'd4,
    CMD_UP       = 3'd5,
    CMD_DOWN     = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Fit view samples rows 1,3,5,7 and cols 1,4,7,10.
  function automatic logic [3:0] fit_row(input logic [1:0] i);
    case (i)
      2'd0:    return 4'd1;
      2'd1:    return 4'd3;
      2'd2:    return 4'd5;
      default: return 4'd7;
    endcase
  endfunction

  function automatic logic [3:0] fit_col(input logic [1:0] j);
    case (j)
      2'd0:    return 4'd1;
      2'd1:    return 4'd4;
      2'd2:    return 4'd7;
      default: return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/lcd_addr_gen.sv
// lcd_addr_gen
// Combinational mapping from view mode, window origin and output counter to
// a pixel buffer index (row*stride + col).
// Ports:
//   fit_mode  in   1 = fit view, 0 = zoom window
//   r0, c0    in   window origin (row, col)
//   out_cnt   in   output pixel number 0..15, raster order
//   idx       out  buffer index
module lcd_addr_gen #(
  parameter int ROW_STRIDE = 12,
  parameter int IW         = 7
) (
  input  logic          fit_mode,
  input  logic [3:0]    r0,
  input  logic [3:0]    c0,
  input  logic [3:0]    out_cnt,
  output logic [IW-1:0] idx
);
  import lcd_ctrl_pkg::*;

  logic [1:0] i, j;
  logic [3:0] row, col;

  assign i = out_cnt[3:2];
  assign j = out_cnt[1:0];

  always_comb begin
    if (fit_mode) begin
      row = fit_row(i);
      col = fit_col(j);
    end else begin
      row = r0 + {2'b00, i};
      col = c0 + {2'b00, j};
    end
    idx = IW'(row) * IW'(ROW_STRIDE) + IW'(col);
  end

endmodule

// File: rtl/lcd_ctrl_core.sv
// lcd_ctrl_core
// Stores an IMG_W x IMG_H 8-bit image and, after every command, streams a
// 4x4 view (fit or zoom window) as 16 consecutive valid pixels.
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high
//   datain[7:0]   in   pixel stream during Load
//   cmd[2:0]      in   command code, qualified by cmd_valid
//   cmd_valid     in   command strobe, honoured only while busy=0
//   dataout[7:0]  out  output pixel (registered)
//   output_valid  out  dataout valid this cycle
//   busy          out  command executing; new commands ignored
//
// state   | meaning
// IDLE    | waiting for a command
// LOAD    | writing one pixel per cycle into the buffer
// OUT     | reading 16 view pixels, one per cycle
module lcd_ctrl_core #(
  parameter int IMG_W = 12,
  parameter int IMG_H = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] datain,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic [7:0] dataout,
  output logic       output_valid,
  output logic       busy
);
  import lcd_ctrl_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int IW   = $clog2(NPIX);

  state_e        state_q, state_d;
  logic [IW-1:0] wr_idx;
  logic [3:0]    out_cnt;
  logic          fit_mode;
  logic [3:0]    r0, c0;
  logic [7:0]    pix_mem [NPIX];
  logic [IW-1:0] rd_idx;
  logic          cap, load_last, out_last;
  logic [7:0]    dataout_d;
  logic          valid_d;

  // The last output pixel is presented one cycle after the FSM has returned
  // to IDLE, so busy also covers that cycle to keep it ahead of new capture.
  assign busy      = (state_q != ST_IDLE) || output_valid;
  assign cap       = (state_q == ST_IDLE) && !output_valid && cmd_valid;
  assign load_last = (state_q == ST_LOAD) && (wr_idx == IW'(NPIX - 1));
  assign out_last  = (state_q == ST_OUT) && (out_cnt == 4'(WIN * WIN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cap) state_d = (cmd == CMD_LOAD) ? ST_LOAD : ST_OUT;
      ST_LOAD: if (load_last) state_d = ST_OUT;
      ST_OUT:  if (out_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dataout_d = 8'd0;
    valid_d   = 1'b0;
    if (state_q == ST_OUT) begin
      dataout_d = pix_mem[rd_idx];
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataout      <= 8'd0;
      output_valid <= 1'b0;
    end else begin
      dataout      <= dataout_d;
      output_valid <= valid_d;
    end
  end

  // Counters and view state; mode/origin change only on command capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx   <= '0;
      out_cnt  <= 4'd0;
      fit_mode <= 1'b1;
      r0       <= DEF_R0;
      c0       <= DEF_C0;
    end else begin
      if (state_q == ST_LOAD) wr_idx <= wr_idx + 1'b1;
      if (state_q == ST_OUT)  out_cnt <= out_cnt + 4'd1;
      if (cap) begin
        wr_idx  <= '0;
        out_cnt <= 4'd0;
        case (cmd)
          CMD_LOAD: begin
            fit_mode <= 1'b1;
            r0       <= DEF_R0;
            c0       <= DEF_C0;
          end
          CMD_ZOOM_IN: if (fit_mode) begin
            fit_mode <= 1'b0;
            r0       <= DEF_R0;
            c0       <= DEF_C0;
          end
          CMD_ZOOM_FIT: fit_mode <= 1'b1;
          CMD_RIGHT: if (!fit_mode && c0 < MAX_C0) c0 <= c0 + 4'd1;
          CMD_LEFT:  if (!fit_mode && c0 != 4'd0)  c0 <= c0 - 4'd1;
          CMD_UP:    if (!fit_mode && r0 != 4'd0)  r0 <= r0 - 4'd1;
          CMD_DOWN:  if (!fit_mode && r0 < MAX_R0) r0 <= r0 + 4'd1;
          default: ;
        endcase
      end
    end
  end

  // Buffer contents survive reset; reset forces IDLE so no write follows.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) pix_mem[wr_idx] <= datain;
  end

  lcd_addr_gen #(
    .ROW_STRIDE(IMG_W),
    .IW        (IW)
  ) u_addr_gen (
    .fit_mode(fit_mode),
    .r0      (r0),
    .c0      (c0),
    .out_cnt (out_cnt),
    .idx     (rd_idx)
  );

endmodule

// File: tb/tb_lcd_ctrl_core.sv
module tb_lcd_ctrl_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] datain;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  lcd_ctrl_core #(.IMG_W(12), .IMG_H(9)) dut (
    .clk         (clk),
    .reset       (reset),
    .datain      (datain),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .dataout     (dataout),
    .output_valid(output_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: image array, view mode and window origin.
  int img [108];
  int load_buf [108];
  int m_fit, m_r0, m_c0;
  int exp_q [$];
  int got [16];
  int got_n;

  function automatic int view(input int k);
    int i = k / 4;
    int j = k % 4;
    if (m_fit != 0) return img[(1 + 2 * i) * 12 + 1 + 3 * j];
    return img[(m_r0 + i) * 12 + m_c0 + j];
  endfunction

  function automatic void model_cmd(input int c);
    case (c)
      0: begin
        for (int k = 0; k < 108; k++) img[k] = load_buf[k];
        m_fit = 1; m_r0 = 2; m_c0 = 4;
      end
      1: if (m_fit != 0) begin m_fit = 0; m_r0 = 2; m_c0 = 4; end
      2: m_fit = 1;
      3: if (m_fit == 0) m_c0 = (m_c0 + 1 > 8) ? 8 : m_c0 + 1;
      4: if (m_fit == 0) m_c0 = (m_c0 - 1 < 0) ? 0 : m_c0 - 1;
      5: if (m_fit == 0) m_r0 = (m_r0 - 1 < 0) ? 0 : m_r0 - 1;
      6: if (m_fit == 0) m_r0 = (m_r0 + 1 > 5) ? 5 : m_r0 + 1;
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every valid output pixel against the model queue.
  always @(negedge clk) begin
    if (!reset && output_valid) begin
      int e;
      vectors++;
      if (got_n < 16) got[got_n] = dataout;
      got_n++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got %0h expected no output", dataout);
      end else begin
        e = exp_q.pop_front();
        if (dataout !== 8'(e)) begin
          miscompares++;
          $display("FAIL pixel: got %0h expected %0h", dataout, e);
        end
      end
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_during_out: got %0b expected 1", busy);
      end
    end
  end

  task automatic noise(input bit en);
    if (en) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd       = 3'($urandom_range(0, 7));
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  // Issue one command from an idle negedge and follow it to completion.
  task automatic run_cmd(input int c, input bit rnd);
    int lat;
    check("idle_before_cmd", busy, 0);
    cmd = 3'(c);
    cmd_valid = 1'b1;
    model_cmd(c);
    for (int k = 0; k < 16; k++) exp_q.push_back(view(k));
    got_n = 0;
    @(negedge clk);
    noise(rnd);
    if (c == 0) begin
      for (int k = 0; k < 108; k++) begin
        datain = 8'(load_buf[k]);
        noise(rnd);
        @(negedge clk);
      end
    end
    lat = 1;
    while (!output_valid && lat < 3) begin
      noise(rnd);
      @(negedge clk);
      lat++;
    end
    if (!output_valid) begin
      miscompares++;
      $display("FAIL first_valid_latency: got no valid by cycle %0d expected <= 3", lat);
    end
    for (int n = 0; n < 16; n++) begin
      check("valid_run", int'(output_valid), 1);
      noise(rnd && n < 15);
      @(negedge clk);
    end
    check("busy_after_out", busy, 0);
    check("valid_after_out", output_valid, 0);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pin16(input string name, input int ref16 [16]);
    for (int k = 0; k < 16; k++) check(name, got[k], ref16[k]);
  endtask

  int fit_ref [16] = '{'h0D, 'h10, 'h13, 'h16, 'h25, 'h28, 'h2B, 'h2E,
                       'h3D, 'h40, 'h43, 'h46, 'h55, 'h58, 'h5B, 'h5E};
  int zoom_ref [16] = '{'h1C, 'h1D, 'h1E, 'h1F, 'h28, 'h29, 'h2A, 'h2B,
                        'h34, 'h35, 'h36, 'h37, 'h40, 'h41, 'h42, 'h43};

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = 3'd0;
    datain = 8'd0;
    got_n = 0;
    m_fit = 1; m_r0 = 2; m_c0 = 4;
    for (int k = 0; k < 108; k++) img[k] = 0;
    repeat (3) @(negedge clk);
    check("reset_dataout", dataout, 0);
    check("reset_valid", output_valid, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 108; k++) load_buf[k] = k;
    run_cmd(0, 0);
    pin16("load_fit", fit_ref);
    run_cmd(1, 0);
    pin16("zoom_in", zoom_ref);

    repeat (5) run_cmd(3, 0);
    check("right_sat_0", got[0], 'h20);
    check("right_sat_1", got[1], 'h21);
    check("right_sat_2", got[2], 'h22);
    check("right_sat_3", got[3], 'h23);
    repeat (4) run_cmd(6, 0);
    check("down_sat", got[0], 'h44);
    repeat (7) run_cmd(5, 0);
    check("up_sat", got[0], 'h08);

    run_cmd(2, 0);
    run_cmd(4, 0);
    pin16("left_in_fit", fit_ref);
    run_cmd(1, 0);
    pin16("zoom_restore", zoom_ref);

    for (int n = 0; n < 60; n++) begin
      int c = $urandom_range(0, 7);
      if (c == 0 && $urandom_range(0, 3) != 0) c = 1 + $urandom_range(0, 6);
      if (c == 0)
        for (int k = 0; k < 108; k++) load_buf[k] = $urandom_range(0, 255);
      run_cmd(c, 1);
    end

    // Reset in the middle of a Load: the first 50 pixels have been written.
    for (int k = 0; k < 108; k++) load_buf[k] = $urandom_range(0, 255);
    cmd = 3'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      datain = 8'(load_buf[k]);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("midload_reset_dataout", dataout, 0);
    check("midload_reset_valid", output_valid, 0);
    check("midload_reset_busy", busy, 0);
    for (int k = 0; k < 50; k++) img[k] = load_buf[k];
    m_fit = 1; m_r0 = 2; m_c0 = 4;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle_busy", busy, 0);
      check("post_reset_idle_valid", output_valid, 0);
    end
    run_cmd(7, 0);
    run_cmd(1, 1);
    run_cmd(6, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
